// File: rtl/rv_mcu_eai_if.sv
// rv_mcu_eai_if: EAI bundle between the host bus model and the accelerator.
//   req_*     : host -> accelerator instruction request (valid/ready, payload, tag)
//   rsp_*     : accelerator -> host instruction response (valid/ready, data, tag, err)
//   icb_cmd_* : accelerator -> host memory command (valid/ready, addr, read, wdata, wmask)
//   icb_rsp_* : host -> accelerator memory response (valid/ready, rdata, err)
//   mem_holdup: accelerator asks the host to defer new requests
// Modport master is the host side, slave is the accelerator side.
interface rv_mcu_eai_if #(
    parameter int unsigned ITAG_W = 2
) ();
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_instr;
    logic [31:0]       req_rs1;
    logic [31:0]       req_rs2;
    logic [ITAG_W-1:0] req_itag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_wdat;
    logic [ITAG_W-1:0] rsp_itag;
    logic              rsp_err;

    logic              icb_cmd_valid;
    logic              icb_cmd_ready;
    logic [31:0]       icb_cmd_addr;
    logic              icb_cmd_read;
    logic [31:0]       icb_cmd_wdata;
    logic [3:0]        icb_cmd_wmask;

    logic              icb_rsp_valid;
    logic              icb_rsp_ready;
    logic [31:0]       icb_rsp_rdata;
    logic              icb_rsp_err;

    logic              mem_holdup;

    modport master (
        output req_valid, req_instr, req_rs1, req_rs2, req_itag,
        input  req_ready,
        input  rsp_valid, rsp_wdat, rsp_itag, rsp_err,
        output rsp_ready,
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        output icb_cmd_ready,
        output icb_rsp_valid, icb_rsp_rdata, icb_rsp_err,
        input  icb_rsp_ready,
        input  mem_holdup
    );

    modport slave (
        input  req_valid, req_instr, req_rs1, req_rs2, req_itag,
        output req_ready,
        output rsp_valid, rsp_wdat, rsp_itag, rsp_err,
        input  rsp_ready,
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_cmd_ready,
        input  icb_rsp_valid, icb_rsp_rdata, icb_rsp_err,
        output icb_rsp_ready,
        output mem_holdup
    );
endinterface

// File: rtl/rv_mcu_eai.sv
// rv_mcu_eai: host-side bus model of the RISC-V MCU driving an accelerator over EAI.
// Turns a one-cycle instruction strobe into an EAI request, consumes the response,
// and serves the accelerator's ICB memory channel from an internal word RAM.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   send_instr      : one-cycle strobe to issue instr/rs1_data/rs2_data
//   instr           : custom instruction word
//   rs1_data        : rs1 operand
//   rs2_data        : rs2 operand
//   eai             : EAI bundle (master modport), see rv_mcu_eai_if
module rv_mcu_eai #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned ITAG_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                send_instr,
    input  logic [31:0]         instr,
    input  logic [31:0]         rs1_data,
    input  logic [31:0]         rs2_data,
    rv_mcu_eai_if.master        eai
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StReq,
        StWaitRsp
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       rs1_q, rs1_d;
    logic [31:0]       rs2_q, rs2_d;
    logic [ITAG_W-1:0] itag_q, itag_d;
    logic              capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            instr_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            itag_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            itag_q  <= itag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        itag_d  = itag_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (send_instr) begin
                    capture = 1'b1;
                    state_d = StPend;
                end
            end
            StPend: begin
                // Holdup only defers the rise of valid; it is not looked at once in StReq.
                if (!eai.mem_holdup) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (eai.req_ready) begin
                    itag_d  = itag_q + ITAG_W'(1);
                    // A response landing in the handshake cycle completes the transaction.
                    state_d = eai.rsp_valid ? StIdle : StWaitRsp;
                end
            end
            StWaitRsp: begin
                if (eai.rsp_valid) begin
                    if (send_instr) begin
                        capture = 1'b1;
                        state_d = StPend;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        instr_d = capture ? instr    : instr_q;
        rs1_d   = capture ? rs1_data : rs1_q;
        rs2_d   = capture ? rs2_data : rs2_q;
    end

    assign eai.req_valid = (state_q == StReq);
    assign eai.req_instr = instr_q;
    assign eai.req_rs1   = rs1_q;
    assign eai.req_rs2   = rs2_q;
    assign eai.req_itag  = itag_q;

    // Responses are always consumed; tag and error are informational only.
    assign eai.rsp_ready = rst_n;

    // ------------------------------------------------------------------
    // ICB memory slave
    // ------------------------------------------------------------------
    logic [31:0]   mem_q [MEM_DEPTH];
    logic          icb_rsp_valid_q;
    logic [31:0]   icb_rsp_rdata_q;
    logic          icb_rsp_err_q;
    logic          cmd_ready;
    logic          cmd_fire;
    logic          in_range;
    logic [AW-1:0] idx;

    // A held response blocks new commands unless it drains in this same cycle.
    assign cmd_ready = rst_n & (~icb_rsp_valid_q | eai.icb_rsp_ready);
    assign cmd_fire  = eai.icb_cmd_valid & cmd_ready;
    assign idx       = eai.icb_cmd_addr[AW+1:2];
    assign in_range  = (eai.icb_cmd_addr[31:AW+2] == '0);

    always_ff @(posedge clk) begin
        if (cmd_fire && !eai.icb_cmd_read && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (eai.icb_cmd_wmask[i]) begin
                    mem_q[idx][8*i +: 8] <= eai.icb_cmd_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icb_rsp_valid_q <= 1'b0;
            icb_rsp_rdata_q <= '0;
            icb_rsp_err_q   <= 1'b0;
        end else if (cmd_fire) begin
            icb_rsp_valid_q <= 1'b1;
            icb_rsp_err_q   <= ~in_range;
            icb_rsp_rdata_q <= (eai.icb_cmd_read && in_range) ? mem_q[idx] : '0;
        end else if (eai.icb_rsp_ready) begin
            icb_rsp_valid_q <= 1'b0;
        end
    end

    assign eai.icb_cmd_ready = cmd_ready;
    assign eai.icb_rsp_valid = icb_rsp_valid_q;
    assign eai.icb_rsp_rdata = icb_rsp_rdata_q;
    assign eai.icb_rsp_err   = icb_rsp_err_q;

    // Byte offset and response payload carry no meaning for this model.
    logic unused_sigs;
    assign unused_sigs = ^{eai.icb_cmd_addr[1:0], eai.rsp_wdat, eai.rsp_itag, eai.rsp_err};

endmodule

// File: tb/tb_rv_mcu_eai.sv
// tb_rv_mcu_eai: directed + randomized checks of rv_mcu_eai against a behavioural model
// (expected tag counter, captured payloads, and a word/byte-lane memory array).
module tb_rv_mcu_eai;
    localparam int unsigned MEM_DEPTH = 1024;
    localparam int unsigned ITAG_W    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        send_instr;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    rv_mcu_eai_if #(.ITAG_W(ITAG_W)) eai ();

    rv_mcu_eai #(
        .MEM_DEPTH (MEM_DEPTH),
        .ITAG_W    (ITAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .send_instr (send_instr),
        .instr      (instr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .eai        (eai)
    );

    always #5 clk = ~clk;

    int          vecs = 0;
    int          miss = 0;
    int          exp_tag = 0;
    logic [31:0] mdl [MEM_DEPTH];
    int          pool [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full instruction transaction; starts and ends with the FSM idle at posedge+1.
    task automatic do_req(input int hold, input int stall, input bit rsp_same,
                          input bit late_strobe, input bit chain);
        logic [31:0] i, a, b, i2, a2;
        i = $urandom; a = $urandom; b = $urandom;
        send_instr = 1'b1; instr = i; rs1_data = a; rs2_data = b;
        eai.mem_holdup = (hold > 0); eai.req_ready = 1'b0;
        cyc();
        send_instr = 1'b0; instr = $urandom; rs1_data = $urandom; rs2_data = $urandom;
        chk("pend_valid", 32'(eai.req_valid), 32'd0);
        chk("pend_instr", eai.req_instr, i);
        for (int h = 0; h < hold; h++) begin
            cyc();
            chk("holdup_valid", 32'(eai.req_valid), 32'd0);
        end
        eai.mem_holdup = 1'b0;
        cyc();
        chk("req_valid", 32'(eai.req_valid), 32'd1);
        chk("req_instr", eai.req_instr, i);
        chk("req_rs1", eai.req_rs1, a);
        chk("req_rs2", eai.req_rs2, b);
        chk("req_itag", 32'(eai.req_itag), 32'(exp_tag));
        for (int s = 0; s < stall; s++) begin
            eai.mem_holdup = 1'($urandom_range(0, 1));
            cyc();
            chk("stall_valid", 32'(eai.req_valid), 32'd1);
            chk("stall_instr", eai.req_instr, i);
            chk("stall_rs1", eai.req_rs1, a);
            chk("stall_rs2", eai.req_rs2, b);
        end
        eai.mem_holdup = 1'b0;
        eai.req_ready = 1'b1;
        eai.rsp_valid = rsp_same;
        eai.rsp_itag = ITAG_W'(exp_tag);
        eai.rsp_err = 1'($urandom_range(0, 1));
        eai.rsp_wdat = $urandom;
        cyc();
        eai.req_ready = 1'b0; eai.rsp_valid = 1'b0;
        exp_tag = (exp_tag + 1) % (1 << ITAG_W);
        chk("hs_valid_drop", 32'(eai.req_valid), 32'd0);
        chk("hs_itag", 32'(eai.req_itag), 32'(exp_tag));
        if (!rsp_same) begin
            if (chain) begin
                i2 = $urandom; a2 = $urandom;
                send_instr = 1'b1; instr = i2; rs1_data = a2; eai.rsp_valid = 1'b1;
                cyc();
                send_instr = 1'b0; eai.rsp_valid = 1'b0;
                chk("chain_pend_valid", 32'(eai.req_valid), 32'd0);
                chk("chain_instr", eai.req_instr, i2);
                cyc();
                chk("chain_valid", 32'(eai.req_valid), 32'd1);
                chk("chain_rs1", eai.req_rs1, a2);
                chk("chain_itag", 32'(eai.req_itag), 32'(exp_tag));
                eai.req_ready = 1'b1; eai.rsp_valid = 1'b1;
                cyc();
                eai.req_ready = 1'b0; eai.rsp_valid = 1'b0;
                exp_tag = (exp_tag + 1) % (1 << ITAG_W);
                chk("chain_itag_inc", 32'(eai.req_itag), 32'(exp_tag));
            end else begin
                if (late_strobe) begin
                    send_instr = 1'b1; instr = $urandom;
                    cyc();
                    send_instr = 1'b0;
                    chk("ignored_strobe", 32'(eai.req_valid), 32'd0);
                end
                eai.rsp_valid = 1'b1;
                cyc();
                eai.rsp_valid = 1'b0;
            end
        end
        cyc();
        chk("idle_valid", 32'(eai.req_valid), 32'd0);
    endtask

    // One ICB command with the response accepted immediately.
    task automatic icb(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] wm);
        logic [31:0] idx;
        logic [31:0] exp_d;
        bit          ok;
        idx = addr >> 2;
        ok = (idx < MEM_DEPTH);
        exp_d = '0;
        if (ok && rd) exp_d = mdl[idx[9:0]];
        if (ok && !rd) begin
            for (int k = 0; k < 4; k++) begin
                if (wm[k]) mdl[idx[9:0]][8*k +: 8] = wd[8*k +: 8];
            end
        end
        eai.icb_cmd_valid = 1'b1; eai.icb_cmd_read = rd; eai.icb_cmd_addr = addr;
        eai.icb_cmd_wdata = wd; eai.icb_cmd_wmask = wm; eai.icb_rsp_ready = 1'b1;
        #1;
        chk("icb_cmd_ready", 32'(eai.icb_cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        eai.icb_cmd_valid = 1'b0;
        chk("icb_rsp_valid", 32'(eai.icb_rsp_valid), 32'd1);
        chk("icb_rdata", eai.icb_rsp_rdata, exp_d);
        chk("icb_err", 32'(eai.icb_rsp_err), 32'(!ok));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_a, exp_b, addr;
        rst_n = 1'b0; send_instr = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0;
        eai.req_ready = 1'b0; eai.rsp_valid = 1'b0; eai.rsp_wdat = '0; eai.rsp_itag = '0;
        eai.rsp_err = 1'b0; eai.icb_cmd_valid = 1'b0; eai.icb_cmd_addr = '0;
        eai.icb_cmd_read = 1'b0; eai.icb_cmd_wdata = '0; eai.icb_cmd_wmask = '0;
        eai.icb_rsp_ready = 1'b0; eai.mem_holdup = 1'b0;
        #2;
        chk("rst_req_valid", 32'(eai.req_valid), 32'd0);
        chk("rst_req_instr", eai.req_instr, 32'd0);
        chk("rst_rsp_ready", 32'(eai.rsp_ready), 32'd0);
        chk("rst_cmd_ready", 32'(eai.icb_cmd_ready), 32'd0);
        chk("rst_icb_rsp_valid", 32'(eai.icb_rsp_valid), 32'd0);
        chk("rst_itag", 32'(eai.req_itag), 32'd0);
        #10;
        rst_n = 1'b1;
        cyc();
        chk("post_rst_rsp_ready", 32'(eai.rsp_ready), 32'd1);
        chk("post_rst_cmd_ready", 32'(eai.icb_cmd_ready), 32'd1);

        // Fixed first transaction, then the tag must have advanced to 1.
        send_instr = 1'b1; instr = 32'h0000_700B; rs1_data = 32'h10; rs2_data = 32'h20;
        eai.req_ready = 1'b1;
        cyc();
        send_instr = 1'b0;
        chk("first_pend_valid", 32'(eai.req_valid), 32'd0);
        cyc();
        chk("first_valid", 32'(eai.req_valid), 32'd1);
        chk("first_instr", eai.req_instr, 32'h0000_700B);
        chk("first_rs1", eai.req_rs1, 32'h10);
        chk("first_rs2", eai.req_rs2, 32'h20);
        chk("first_itag", 32'(eai.req_itag), 32'd0);
        cyc();
        eai.req_ready = 1'b0;
        exp_tag = 1;
        chk("first_drop", 32'(eai.req_valid), 32'd0);
        eai.rsp_valid = 1'b1;
        cyc();
        eai.rsp_valid = 1'b0;

        do_req(0, 5, 0, 0, 0);   // itag 1, five stall cycles
        do_req(3, 0, 0, 1, 0);   // holdup in PEND, ignored strobe in WAIT_RSP
        do_req(0, 1, 0, 0, 1);   // strobe captured alongside response
        for (int n = 0; n < 8; n++) begin
            do_req($urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0);
        end

        // ICB: directed byte-lane merge and out-of-range read.
        icb(1'b0, 32'h8, 32'h0, 4'hF);
        icb(1'b0, 32'h8, 32'hAABB_CCDD, 4'b0101);
        icb(1'b1, 32'h8, 32'h0, 4'h0);
        chk("lane_merge", eai.icb_rsp_rdata, 32'h00BB_00DD);
        icb(1'b1, 32'(4 * MEM_DEPTH), 32'h0, 4'h0);

        // ICB: randomized back-to-back traffic over a small word pool.
        for (int k = 0; k < 8; k++) begin
            pool[k] = $urandom_range(0, MEM_DEPTH - 1);
            icb(1'b0, 32'(pool[k]) << 2, $urandom, 4'hF);
        end
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                addr = ($urandom_range(MEM_DEPTH, 32'h3FFF_FFFF) << 2) | 32'($urandom_range(0, 3));
            end else begin
                addr = (32'(pool[$urandom_range(0, 7)]) << 2) | 32'($urandom_range(0, 3));
            end
            icb(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
        end
        cyc();
        chk("icb_drain", 32'(eai.icb_rsp_valid), 32'd0);

        // ICB: response held while a second command waits.
        exp_a = mdl[pool[0]];
        exp_b = mdl[pool[1]];
        icb(1'b1, 32'(pool[0]) << 2, 32'h0, 4'h0);
        eai.icb_rsp_ready = 1'b0;
        eai.icb_cmd_valid = 1'b1; eai.icb_cmd_read = 1'b1; eai.icb_cmd_addr = 32'(pool[1]) << 2;
        #1;
        chk("hold_cmd_ready0", 32'(eai.icb_cmd_ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("hold_rsp_valid", 32'(eai.icb_rsp_valid), 32'd1);
            chk("hold_rdata", eai.icb_rsp_rdata, exp_a);
            chk("hold_cmd_ready", 32'(eai.icb_cmd_ready), 32'd0);
        end
        eai.icb_rsp_ready = 1'b1;
        #1;
        chk("release_cmd_ready", 32'(eai.icb_cmd_ready), 32'd1);
        cyc();
        eai.icb_cmd_valid = 1'b0;
        chk("second_rsp_valid", 32'(eai.icb_rsp_valid), 32'd1);
        chk("second_rdata", eai.icb_rsp_rdata, exp_b);
        cyc();
        chk("second_drain", 32'(eai.icb_rsp_valid), 32'd0);

        // Asynchronous reset in the middle of a request with an ICB response held.
        send_instr = 1'b1; instr = $urandom; rs1_data = $urandom; rs2_data = $urandom;
        eai.icb_cmd_valid = 1'b1; eai.icb_cmd_read = 1'b1; eai.icb_cmd_addr = 32'(pool[2]) << 2;
        eai.icb_rsp_ready = 1'b1;
        cyc();
        send_instr = 1'b0; eai.icb_cmd_valid = 1'b0; eai.icb_rsp_ready = 1'b0;
        cyc();
        chk("mid_req_valid", 32'(eai.req_valid), 32'd1);
        chk("mid_icb_valid", 32'(eai.icb_rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", 32'(eai.req_valid), 32'd0);
        chk("arst_icb_valid", 32'(eai.icb_rsp_valid), 32'd0);
        chk("arst_rsp_ready", 32'(eai.rsp_ready), 32'd0);
        chk("arst_itag", 32'(eai.req_itag), 32'd0);
        #1;
        rst_n = 1'b1;
        exp_tag = 0;
        cyc();
        chk("post_arst_idle", 32'(eai.req_valid), 32'd0);
        chk("post_arst_icb", 32'(eai.icb_rsp_valid), 32'd0);
        do_req(0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule

// File: doc/rv_mcu_eai.md
Name: rv_mcu_eai

Overview:
Host-side bus model of the RISC-V MCU that drives the HWPE accelerator over the EAI (extension accelerator interface).
- Converts a one-cycle instruction strobe (instr, rs1, rs2) into an EAI request and consumes the matching EAI response.
- Serves the accelerator's ICB memory channel from an internal word-addressed RAM.
- Sits beside hwpe in system/test builds and stands in for the E203-style core.

Parameters:
MEM_DEPTH, 1024, number of 32-bit words in the ICB-backed RAM (power of two).
ITAG_W, 2, width of the instruction tag.

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
send_instr  in  1  one-cycle strobe: issue instr/rs1_data/rs2_data
instr  in  32  custom instruction word
rs1_data  in  32  rs1 operand
rs2_data  in  32  rs2 operand
eai_req_valid  out  1  request valid
eai_req_ready  in  1  accelerator accepts request
eai_req_instr  out  32  registered instr
eai_req_rs1  out  32  registered rs1
eai_req_rs2  out  32  registered rs2
eai_req_itag  out  ITAG_W  tag of current request
eai_rsp_valid  in  1  response valid
eai_rsp_ready  out  1  response accept
eai_rsp_wdat  in  32  response write-back data
eai_rsp_itag  in  ITAG_W  response tag
eai_rsp_err  in  1  response error
eai_icb_cmd_valid  in  1  memory command valid
eai_icb_cmd_ready  out  1  memory command accept
eai_icb_cmd_addr  in  32  byte address
eai_icb_cmd_read  in  1  1=read, 0=write
eai_icb_cmd_wdata  in  32  write data
eai_icb_cmd_wmask  in  4  byte-lane enables
eai_icb_rsp_valid  out  1  memory response valid
eai_icb_rsp_ready  in  1  accelerator accepts memory response
eai_icb_rsp_rdata  out  32  read data
eai_icb_rsp_err  out  1  address out of range
eai_mem_holdup  in  1  accelerator asks host to defer new requests

Behaviour:
- Reset (rst_n low, async) values:
  - All outputs 0.
  - Request FSM goes to IDLE; itag=0; pending instruction discarded.
  - Any ICB response in flight is dropped.
  - RAM contents are not reset.
- Request FSM states are IDLE, PEND, REQ and WAIT_RSP.
  - IDLE: send_instr=1 captures instr/rs1/rs2 into the eai_req_* registers. Go to PEND.
  - PEND: when eai_mem_holdup=0, go to REQ. eai_req_valid rises the following cycle, so there is at least 1 cycle from strobe to valid.
  - REQ: eai_req_valid=1 and payload stable until eai_req_ready=1. On handshake, valid drops the next cycle and itag increments (wraps mod 2^ITAG_W).
    - If eai_rsp_valid is also 1 in the handshake cycle, go to IDLE.
    - Otherwise go to WAIT_RSP.
  - WAIT_RSP: on eai_rsp_valid, go to IDLE. If send_instr is also 1 in that cycle, capture it and go to PEND.
  - send_instr in any other state is ignored.
  - eai_mem_holdup never withdraws an asserted eai_req_valid.
- Response handling:
  - eai_rsp_ready=1 whenever out of reset.
  - Responses arriving outside REQ/WAIT_RSP are consumed and ignored.
  - rsp_itag and rsp_err do not alter FSM flow.
- ICB slave:
  - eai_icb_cmd_ready=1 when no response is held, or when the held response is being accepted this cycle.
  - On cmd handshake, eai_icb_rsp_valid=1 next cycle (1-cycle latency).
  - Word index = addr[31:2]. addr[1:0] is ignored.
  - Write: each lane i with wmask[i]=1 writes wdata[8i+7:8i]. rdata=0.
  - Read: rdata = mem[index].
  - Index >= MEM_DEPTH: rsp_err=1, rdata=0, write suppressed.
  - The response holds until eai_icb_rsp_ready=1. Back-to-back commands are accepted every cycle when rsp_ready stays 1.

Test Plan:
- Reset then send_instr with instr=0x0000_700B, rs1=0x10, rs2=0x20, req_ready=1 -> valid high exactly 1 cycle after PEND, payload matches, itag=0. The next issued request carries itag=1.
- req_ready held low 5 cycles -> eai_req_valid and payload stable all 5 cycles. Handshake on cycle 6, valid low on cycle 7.
- eai_mem_holdup=1 during PEND for 3 cycles -> valid stays 0, then asserts. Strobe sent during WAIT_RSP without rsp_valid -> ignored, no second request.
- Five back-to-back strobe/response sequences -> itag sequence is 0,1,2,3,0 with one eai_req_valid per strobe.
- ICB write addr=0x8, wdata=0xAABBCCDD, wmask=0b0101, then read 0x8 -> rdata 0x00BB00DD (after prior write of 0). Read addr 4*MEM_DEPTH -> rsp_err=1, rdata=0.
- ICB rsp_ready low for 2 cycles with a second cmd pending -> cmd_ready=0, first response held. rst_n pulsed low mid-REQ -> eai_req_valid and icb_rsp_valid drop immediately, FSM returns to IDLE.
